// File: rtl/ad_ip_jesd204_tpl_adc_pn_sweep_if.sv
// Bundles the control, status and PN-monitor signals of the PN sweep scheduler.
// Latency: none (wires only).
// Backpressure: none; start is a single-cycle request, ignored while busy.
interface ad_ip_jesd204_tpl_adc_pn_sweep_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DWELL_W      = 16
);
  logic                        start;
  logic                        abort;
  logic [NUM_CHANNELS-1:0]     channel_mask;
  logic [3:0]                  pattern_sel;
  logic [DWELL_W-1:0]          dwell_cycles;
  logic [NUM_CHANNELS-1:0]     pn_err;
  logic [NUM_CHANNELS-1:0]     pn_oos;
  logic [4*NUM_CHANNELS-1:0]   pn_seq_sel;
  logic                        busy;
  logic                        done;
  logic [NUM_CHANNELS-1:0]     pass;
  logic [NUM_CHANNELS-1:0]     oos_seen;
  logic [8*NUM_CHANNELS-1:0]   err_count;

  // Regmap/core side: drives requests and PN flags, observes results.
  modport master (
    output start, abort, channel_mask, pattern_sel, dwell_cycles, pn_err, pn_oos,
    input  pn_seq_sel, busy, done, pass, oos_seen, err_count
  );

  // Scheduler side.
  modport slave (
    input  start, abort, channel_mask, pattern_sel, dwell_cycles, pn_err, pn_oos,
    output pn_seq_sel, busy, done, pass, oos_seen, err_count
  );
endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_pn_sweep.sv
// Steps through masked channels: select PN code, settle, count PN errors/OOS over a dwell, latch pass.
// Latency: sweep takes k*(SETTLE_CYCLES+D+2)+1 busy cycles, done pulses the cycle after.
// Backpressure: none; start ignored while busy, abort returns to idle on the next edge.
module ad_ip_jesd204_tpl_adc_pn_sweep #(
  parameter int         NUM_CHANNELS  = 4,
  parameter int         SETTLE_CYCLES = 256,
  parameter int         DWELL_W       = 16,
  parameter logic [3:0] DEFAULT_SEL   = 4'h0
) (
  input  logic clk,
  input  logic resetn,
  ad_ip_jesd204_tpl_adc_pn_sweep_if.slave bus
);

  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W = (DWELL_W > SET_W) ? DWELL_W : SET_W;
  localparam logic [CNT_W-1:0]   CNT_ONE    = 1;
  localparam logic [CNT_W-1:0]   SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = 1;

  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, DWELL, NEXT} state_t;

  state_t                         state_q, state_d;
  logic [NUM_CHANNELS-1:0]        rem_q, rem_d;     // masked channels not yet visited
  logic [CH_W-1:0]                ch_q, ch_d;       // channel under test
  logic [3:0]                     pat_q, pat_d;
  logic [DWELL_W-1:0]             dwell_q, dwell_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;     // shared settle/dwell down-counter
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic [NUM_CHANNELS-1:0]        pass_q, pass_d;
  logic [NUM_CHANNELS-1:0]        oos_q, oos_d;
  logic [NUM_CHANNELS-1:0][7:0]   errc_q, errc_d;
  logic [NUM_CHANNELS-1:0][3:0]   sel_q, sel_d;

  logic                           nxt_vld;
  logic [CH_W-1:0]                nxt_ch;

  // Lowest-index channel still pending in this sweep.
  always_comb begin
    nxt_vld = 1'b0;
    nxt_ch  = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (rem_q[i]) begin
        nxt_vld = 1'b1;
        nxt_ch  = CH_W'(i);
      end
    end
  end

  // Next-state, result accumulation and registered-output decode.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ch_d    = ch_q;
    pat_d   = pat_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    oos_d   = oos_q;
    errc_d  = errc_q;
    done_d  = 1'b0;

    // Abort beats every transition; results already latched are left untouched.
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = SELECT;
            rem_d   = bus.channel_mask;
            pat_d   = bus.pattern_sel;
            dwell_d = (bus.dwell_cycles == '0) ? DWELL_ONE : bus.dwell_cycles;
            pass_d  = '0;
            oos_d   = '0;
            errc_d  = '0;
          end
        end
        SELECT: begin
          if (nxt_vld) begin
            state_d       = SETTLE;
            ch_d          = nxt_ch;
            rem_d[nxt_ch] = 1'b0;
            cnt_d         = SETTLE_LD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = DWELL;
            cnt_d   = CNT_W'(dwell_q) - CNT_ONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        DWELL: begin
          if (bus.pn_err[ch_q] && (errc_q[ch_q] != 8'hFF)) begin
            errc_d[ch_q] = errc_q[ch_q] + 8'd1;
          end
          if (bus.pn_oos[ch_q]) begin
            oos_d[ch_q] = 1'b1;
          end
          if (cnt_q == '0) begin
            state_d = NEXT;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        NEXT: begin
          pass_d[ch_q] = (errc_q[ch_q] == 8'd0) && !oos_q[ch_q];
          state_d      = SELECT;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);

    // Only the channel under test sees the pattern, from SETTLE entry until NEXT exit.
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sel_d[i] = DEFAULT_SEL;
    end
    if ((state_d == SETTLE) || (state_d == DWELL) || (state_d == NEXT)) begin
      sel_d[ch_d] = pat_d;
    end
  end

  // State and output registers; reset returns everything to idle defaults.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ch_q    <= '0;
      pat_q   <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= '0;
      oos_q   <= '0;
      errc_q  <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        sel_q[i] <= DEFAULT_SEL;
      end
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ch_q    <= ch_d;
      pat_q   <= pat_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      oos_q   <= oos_d;
      errc_q  <= errc_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.pn_seq_sel = sel_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.oos_seen   = oos_q;
  assign bus.err_count  = errc_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_sweep.sv
// Bench for the PN sweep scheduler: vector table plus hand-written corner sequences.
// Latency: checks exact busy length and done cycle per sweep.
// Backpressure: exercises start-while-busy, abort and mid-sweep reset.
module tb_ad_ip_jesd204_tpl_adc_pn_sweep;
  localparam int NC = 4;
  localparam int SC = 4;
  localparam int DW = 16;
  localparam logic [15:0] DEF_ALL = 16'hAAAA;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_adc_pn_sweep_if #(.NUM_CHANNELS(NC), .DWELL_W(DW)) bus ();

  ad_ip_jesd204_tpl_adc_pn_sweep #(
    .NUM_CHANNELS(NC), .SETTLE_CYCLES(SC), .DWELL_W(DW), .DEFAULT_SEL(4'hA)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  pat;
    logic [15:0] dwell;
    logic [3:0]  errm;
    logic [3:0]  oosm;
    int          n;
    logic [3:0]  pass;
    logic [3:0]  oos;
    logic [31:0] errc;
  } vec_t;

  typedef struct {
    int          n;
    logic [3:0]  pass;
    logic [3:0]  oos;
    logic [31:0] errc;
  } exp_t;

  exp_t sb[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_n = 0;
  int   done_n = 0;
  int   done_cyc = 0;
  logic done_busy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Advance to the next falling edge and record busy/done activity.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.busy) busy_n++;
    if (bus.done) begin
      done_n++;
      done_cyc  = cyc;
      done_busy = bus.busy;
    end
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  // Issue a one-cycle start; on return we are in cycle 1 of the sweep.
  task automatic kick(input logic [3:0] m, input logic [3:0] p, input logic [15:0] d);
    @(negedge clk);
    bus.channel_mask = m;
    bus.pattern_sel  = p;
    bus.dwell_cycles = d;
    bus.start        = 1'b1;
    cyc = 0; busy_n = 0; done_n = 0; done_cyc = 0; done_busy = 1'b0;
    step();
    bus.start = 1'b0;
  endtask

  // Wait for done (bounded), then pop the scoreboard and compare.
  task automatic finish_check();
    exp_t e;
    int guard;
    guard = 0;
    while (done_n == 0 && guard < 1000) begin
      step();
      guard++;
    end
    if (done_n == 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done within %0d cycles", guard);
    end
    step();
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: empty when a sweep completed");
      return;
    end
    e = sb.pop_front();
    chk("busy_cycles", 64'(busy_n), 64'(e.n));
    chk("done_cycle", 64'(done_cyc), 64'(e.n + 1));
    chk("busy_at_done", 64'(done_busy), 64'd0);
    chk("done_width", 64'(done_n), 64'd1);
    chk("pass", 64'(bus.pass), 64'(e.pass));
    chk("oos_seen", 64'(bus.oos_seen), 64'(e.oos));
    chk("err_count", 64'(bus.err_count), 64'(e.errc));
    chk("sel_idle", 64'(bus.pn_seq_sel), 64'(DEF_ALL));
  endtask

  initial begin
    vec_t tbl[7];

    bus.start = 1'b0; bus.abort = 1'b0; bus.channel_mask = '0; bus.pattern_sel = '0;
    bus.dwell_cycles = '0; bus.pn_err = '0; bus.pn_oos = '0;

    //           mask     pat   dwell   errm     oosm     N    pass     oos      errc
    tbl[0] = '{4'b0101, 4'h1, 16'd10,  4'b0000, 4'b0000, 33,  4'b0101, 4'b0000, 32'h0000_0000};
    tbl[1] = '{4'b0010, 4'h3, 16'd300, 4'b0010, 4'b0000, 307, 4'b0000, 4'b0000, 32'h0000_FF00};
    tbl[2] = '{4'b0000, 4'h2, 16'd10,  4'b1111, 4'b1111, 1,   4'b0000, 4'b0000, 32'h0000_0000};
    tbl[3] = '{4'b1111, 4'h5, 16'd0,   4'b0000, 4'b0000, 29,  4'b1111, 4'b0000, 32'h0000_0000};
    tbl[4] = '{4'b1001, 4'h6, 16'd5,   4'b1111, 4'b0000, 23,  4'b0000, 4'b0000, 32'h0500_0005};
    tbl[5] = '{4'b0110, 4'h7, 16'd3,   4'b0000, 4'b0100, 19,  4'b0010, 4'b0100, 32'h0000_0000};
    tbl[6] = '{4'b1000, 4'h4, 16'd2,   4'b0111, 4'b0111, 9,   4'b1000, 4'b0000, 32'h0000_0000};

    #1 resetn = 1'b0;
    #11;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_pass", 64'(bus.pass), 64'd0);
    chk("rst_oos", 64'(bus.oos_seen), 64'd0);
    chk("rst_errc", 64'(bus.err_count), 64'd0);
    chk("rst_sel", 64'(bus.pn_seq_sel), 64'(DEF_ALL));
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      bus.pn_err = tbl[i].errm;
      bus.pn_oos = tbl[i].oosm;
      sb.push_back('{tbl[i].n, tbl[i].pass, tbl[i].oos, tbl[i].errc});
      kick(tbl[i].mask, tbl[i].pat, tbl[i].dwell);
      finish_check();
    end
    bus.pn_err = '0;
    bus.pn_oos = '0;

    // pn_seq_sel timing across a two-channel sweep.
    sb.push_back('{33, 4'b0101, 4'b0000, 32'h0});
    kick(4'b0101, 4'h1, 16'd10);
    chk("sel_c1", 64'(bus.pn_seq_sel), 64'(DEF_ALL));
    step_to(2);  chk("sel_c2", 64'(bus.pn_seq_sel), 64'h0000_AAA1);
    step_to(16); chk("sel_c16", 64'(bus.pn_seq_sel), 64'h0000_AAA1);
    step_to(17); chk("sel_c17", 64'(bus.pn_seq_sel), 64'(DEF_ALL));
    step_to(18); chk("sel_c18", 64'(bus.pn_seq_sel), 64'h0000_A1AA);
    step_to(32); chk("sel_c32", 64'(bus.pn_seq_sel), 64'h0000_A1AA);
    step_to(33); chk("sel_c33", 64'(bus.pn_seq_sel), 64'(DEF_ALL));
    finish_check();

    // Errors: one in settle (ignored), three in dwell, noise on other channels.
    sb.push_back('{17, 4'b0000, 4'b0000, 32'h0003_0000});
    kick(4'b0100, 4'h1, 16'd10);
    step_to(3);  bus.pn_err = 4'b0100;
    step_to(4);  bus.pn_err = 4'b0000;
    step_to(7);  bus.pn_err = 4'b0111;
    step_to(10); bus.pn_err = 4'b0000;
    finish_check();

    // Single-cycle OOS pulse during dwell.
    sb.push_back('{11, 4'b0000, 4'b1000, 32'h0});
    kick(4'b1000, 4'h2, 16'd4);
    step_to(7); bus.pn_oos = 4'b1000;
    step_to(8); bus.pn_oos = 4'b0000;
    finish_check();

    // start while busy must not restart or stretch the sweep.
    sb.push_back('{23, 4'b0011, 4'b0000, 32'h0});
    kick(4'b0011, 4'h1, 16'd5);
    step_to(5); bus.start = 1'b1; bus.channel_mask = 4'b1111;
    step_to(6); bus.start = 1'b0;
    finish_check();

    // Abort during ch1 dwell after two error cycles.
    kick(4'b0011, 4'h1, 16'd10);
    step_to(22); bus.pn_err = 4'b0010;
    step_to(24); bus.pn_err = 4'b0000;
    step_to(25); bus.abort = 1'b1;
    step_to(26); bus.abort = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_sel", 64'(bus.pn_seq_sel), 64'(DEF_ALL));
    step_to(36);
    chk("abort_no_done", 64'(done_n), 64'd0);
    chk("abort_pass", 64'(bus.pass), 64'b0001);
    chk("abort_errc", 64'(bus.err_count), 64'h0000_0200);
    chk("abort_oos", 64'(bus.oos_seen), 64'd0);
    sb.push_back('{1, 4'b0000, 4'b0000, 32'h0});
    kick(4'b0000, 4'h1, 16'd1);
    finish_check();

    // Asynchronous reset in the middle of SETTLE.
    kick(4'b0001, 4'h3, 16'd10);
    step_to(3);
    chk("pre_rst_sel", 64'(bus.pn_seq_sel), 64'h0000_AAA3);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_sel", 64'(bus.pn_seq_sel), 64'(DEF_ALL));
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk("post_rst_idle", 64'(bus.busy), 64'd0);
    sb.push_back('{8, 4'b0001, 4'b0000, 32'h0});
    kick(4'b0001, 4'h3, 16'd1);
    finish_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ad_ip_jesd204_tpl_adc_pn_sweep.md
# ad_ip_jesd204_tpl_adc_pn_sweep

Link-clock-domain PN test scheduler for the JESD204 TPL ADC core. It steps through the enabled converter channels one at a time. For each channel it drives that channel's PN sequence select, waits a fixed settle time, then monitors the core's per-channel PN error and out-of-sync flags for a programmable dwell. Per-channel pass/fail results and saturating error counts are latched for the register map. It sits between the TPL regmap and the TPL core, replacing software-driven per-channel PN polling during link bring-up.

## Interface
Parameters:
- NUM_CHANNELS, 4, number of converter channels (1..16)
- SETTLE_CYCLES, 256, clk cycles waited after changing pn_seq_sel before monitoring (>=1)
- DWELL_W, 16, width of dwell_cycles
- DEFAULT_SEL, 4'h0, pn_seq_sel code for channels not under test and while idle

Ports:
- clk  in  1  link clock; all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a sweep; ignored while busy
- abort  in  1  terminate the sweep in progress
- channel_mask  in  NUM_CHANNELS  channels to test; sampled on accepted start
- pattern_sel  in  4  PN code applied to the channel under test; sampled on accepted start
- dwell_cycles  in  DWELL_W  monitor window per channel; sampled on accepted start; 0 treated as 1
- pn_err  in  NUM_CHANNELS  per-channel PN mismatch flags from the core
- pn_oos  in  NUM_CHANNELS  per-channel PN out-of-sync flags from the core
- pn_seq_sel  out  4*NUM_CHANNELS  per-channel PN select to the core (channel i at [4i+3:4i])
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on normal completion
- pass  out  NUM_CHANNELS  per-channel result
- oos_seen  out  NUM_CHANNELS  pn_oos was high during that channel's dwell
- err_count  out  8*NUM_CHANNELS  per-channel count of dwell cycles with pn_err high, saturating at 255

## Operation
- FSM states: IDLE, SELECT, SETTLE, DWELL, NEXT.
- IDLE: start=1 moves to SELECT. The accepted start clears pass, oos_seen and err_count to 0, loads mask, pattern and dwell (0 becomes 1), and sets the current-channel pointer to "none".
- SELECT (1 cycle): picks the lowest-index masked channel above the pointer.
  - If one is found, go to SETTLE.
  - If none remain, go to IDLE with done=1.
- SETTLE: the channel under test drives pattern_sel; all other channels drive DEFAULT_SEL. Lasts exactly SETTLE_CYCLES cycles, then go to DWELL.
- DWELL: lasts exactly D cycles (latched dwell).
  - Each cycle with pn_err[ch]=1 increments err_count[ch], saturating at 255.
  - Any cycle with pn_oos[ch]=1 sets oos_seen[ch].
- NEXT (1 cycle): sets pass[ch] = (err_count[ch]==0) and no oos in the dwell, then go to SELECT.
- Unmasked channels keep pass=0, oos_seen=0, err_count=0.
- abort (any non-IDLE state):
  - Go to IDLE on the next edge; busy drops and done is not pulsed.
  - Results of channels that already finished NEXT are kept. The aborted channel keeps its partial err_count/oos_seen, and its pass stays 0.
  - abort takes priority over every state transition.
- start while busy has no effect. start and abort both high in IDLE: start is accepted (abort is a no-op in IDLE).
- pn_err/pn_oos of channels not under test are ignored.

## Timing
- Reset values:
  - FSM = IDLE
  - busy = 0, done = 0
  - pass = 0, oos_seen = 0, err_count = 0
  - pn_seq_sel = all channels DEFAULT_SEL
- All outputs are registered.
- Cycle numbering: start is sampled at edge 0.
  - busy=1 from cycle 1 through cycle N.
  - done=1 in cycle N+1 only, with busy=0 in that cycle.
  - N = k*(SETTLE_CYCLES + D + 2) + 1, where k = popcount(channel_mask).
  - Empty mask: N=1.
- pn_seq_sel changes on the edge entering SETTLE and returns to DEFAULT_SEL on the edge leaving NEXT.
- pass/oos_seen/err_count are final for channel ch from the cycle after its NEXT.
- pn_err/pn_oos are sampled only during the D DWELL cycles. The SETTLE window is never counted.

## Test plan
- Two-channel sweep, clean link. SETTLE=4, mask=4'b0101, pattern=4'h1, dwell=10, error flags held 0:
  - busy high 33 cycles (2*(4+10+2)+1), then done pulses.
  - pass=4'b0101, all err_count 0.
  - pn_seq_sel shows 4'h1 only on ch0 then ch2 at the expected cycles.
- Error counting and saturation:
  - pn_err[2]=1 for 3 dwell cycles and 1 settle cycle → err_count[2]=3, pass[2]=0.
  - pn_err[1] held high with dwell=300 → err_count[1]=255.
- OOS only: pn_oos[3] pulsed one dwell cycle, no errors → oos_seen[3]=1, pass[3]=0, err_count[3]=0.
- Edge cases:
  - mask=0 → busy for 1 cycle, done next cycle, results 0.
  - dwell=0 → behaves as dwell=1.
  - start during busy → ignored, and the cycle count is unchanged.
- Abort during ch1 DWELL of mask 4'b0011:
  - busy=0 next cycle, no done pulse.
  - ch0 results retained, pass[1]=0.
  - pn_seq_sel all DEFAULT_SEL.
  - A new start clears all results.
- Reset mid-sweep: assert resetn=0 during SETTLE → all outputs return to reset values asynchronously, FSM resumes from IDLE.
